inst_enc: RTL
=============

Name: inst_enc

Overview:
- Streaming RISC-V instruction encoder; the inverse of the decode-side immediate generator.
- Accepts decoded fields (opcode, funct3, funct7, register indices, 32-bit signed immediate) and packs them into a 32-bit instruction word, scattering immediate bits per format.
- Range-checks the immediate against the target format.
- Emits each word with a sequential instruction-memory write address, for the boot loader / bench loader that fills instruction memory.

Parameters:
- ADDR_W, 32, width of addr_o.
- BASE_ADDR, 32'h0000_0000, first write address after reset.
- CNT_W, 8, width of err_cnt_o.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept fields this cycle.
- opcode  in  7  inst[6:0] to emit.
- funct3  in  3  inst[14:12].
- funct7  in  7  inst[31:25]; used only for shifts.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2; S type only.
- imm  in  32  signed immediate, or shamt for shifts.
- out_valid  out  1  inst_o/addr_o/err_o valid.
- out_ready  in  1  consumer accepts the output.
- inst_o  out  32  encoded instruction.
- addr_o  out  ADDR_W  write address for inst_o.
- err_o  out  1  this word was substituted due to an error.
- err_cnt_o  out  CNT_W  saturating count of errored words.

Behaviour:
- Reset, synchronous on clk while rst=1:
  - out_valid=0, inst_o=0, err_o=0, err_cnt_o=0.
  - Internal address counter = BASE_ADDR; addr_o = BASE_ADDR.
  - Any pending word is dropped. rst in mid-stream discards the held output with no acceptance.
- Handshake:
  - Single output register; in_ready = !out_valid || out_ready (combinational).
  - Input accepted when in_valid && in_ready. Encoded word appears on the next edge: latency 1 cycle.
  - Output accepted when out_valid && out_ready.
  - Simultaneous accept-out and accept-in in one cycle: the register reloads with the new word and out_valid stays 1. Full throughput is 1 word/cycle.
  - While out_valid && !out_ready: inst_o, addr_o and err_o are held stable, and in_ready=0.
- Address:
  - addr_o is the address of the word currently presented.
  - The counter advances by 4 on each output acceptance and wraps modulo 2^ADDR_W.
  - Errored (substituted) words also consume an address, keeping the memory image dense.
- Encoding. Fixed fields: inst[6:0]=opcode, inst[14:12]=funct3, inst[19:15]=rs1.
  - I-arith, opcode 7'b0010011:
    - funct3 001 or 101 (shift): inst[31:25]=funct7, inst[24:20]=imm[4:0], inst[11:7]=rd. Legal iff imm[31:5]==0.
    - Other funct3: inst[31:20]=imm[11:0], inst[11:7]=rd. Legal iff imm[31:11] all equal (range -2048..2047).
  - I-load, opcode 7'b0000011: same as I-arith non-shift, including the range rule.
  - S, opcode 7'b0100011: inst[31:25]=imm[11:5], inst[24:20]=rs2, inst[11:7]=imm[4:0]. Same range rule.
  - Any other opcode: error.
- Error handling:
  - inst_o = 32'h0000_0013 (NOP), err_o=1.
  - err_cnt_o increments by 1 when the errored word is loaded into the output register, and saturates at all ones.
  - err_o is per-word; it clears when a legal word is loaded.

Test Plan:
- Reset, then addi x1,x0,5 (op 0x13, f3 0, rd 1, rs1 0, imm 5) -> one cycle later out_valid=1, inst_o=0x00500093, addr_o=0x0, err_o=0.
- lw x2,-4(x3) (op 0x03, f3 2, imm 0xFFFFFFFC), then sw x5,8(x6) (op 0x23, f3 2, rs1 6, rs2 5, imm 8) back-to-back with out_ready=1 -> inst_o=0xFFC1A103 @0x0, then 0x00532423 @0x4; in_ready stays 1 throughout.
- srai x1,x1,3 (f3 5, funct7 0x20, imm 3) -> inst_o=0x4030D093.
- Error cases:
  - addi imm=2048 -> inst_o=0x00000013, err_o=1, err_cnt_o=1.
  - slli imm=32 -> err_cnt_o=2.
  - opcode 0x33 -> err_cnt_o=3.
  - A following legal word -> err_o=0.
- Backpressure:
  - out_ready=0 for 3 cycles with in_valid held -> in_ready=0; inst_o/addr_o stable; no address advance.
  - out_ready=1 -> exactly one acceptance per word, addresses contiguous.
- Reset and counter limits:
  - Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, addr_o=BASE_ADDR, err_cnt_o=0.
  - With CNT_W=2, 5 errors -> err_cnt_o saturates at 3.

Source files
------------

// File: rtl/inst_enc.sv
// Streaming RISC-V instruction encoder: packs decoded fields (I/S formats) into
// 32-bit words with a range-checked immediate and a dense, sequential write address.
module inst_enc #(
   parameter int                 ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = {ADDR_W{1'b0}},
   parameter int                 CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       inst_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  err_cnt_o
);

   localparam logic [6:0]  OP_I_ARITH = 7'b0010011;
   localparam logic [6:0]  OP_I_LOAD  = 7'b0000011;
   localparam logic [6:0]  OP_S       = 7'b0100011;
   localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

   logic              r_valid;
   logic [31:0]       r_inst;
   logic              r_err;
   logic [CNT_W-1:0]  r_err_cnt;
   logic [ADDR_W-1:0] r_addr;

   logic              w_in_acc;
   logic              w_out_acc;
   logic              w_imm12_ok;
   logic              w_shamt_ok;
   logic [31:0]       w_inst;
   logic              w_err;

   // 12-bit signed immediates need imm[31:11] to be a pure sign extension.
   function automatic logic fits_simm12(input logic [31:0] v);
      return (&v[31:11]) || !(|v[31:11]);
   endfunction

   assign in_ready   = !r_valid || out_ready;
   assign w_in_acc   = in_valid && in_ready;
   assign w_out_acc  = r_valid && out_ready;
   assign w_imm12_ok = fits_simm12(imm);
   assign w_shamt_ok = !(|imm[31:5]);

   // Field packing per format; illegal opcode or out-of-range immediate yields a NOP.
   always_comb begin
      w_inst = NOP_WORD;
      w_err  = 1'b1;
      case (opcode)
         OP_I_ARITH: begin
            if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
               w_inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
               w_err  = !w_shamt_ok;
            end else begin
               w_inst = {imm[11:0], rs1, funct3, rd, opcode};
               w_err  = !w_imm12_ok;
            end
         end
         OP_I_LOAD: begin
            w_inst = {imm[11:0], rs1, funct3, rd, opcode};
            w_err  = !w_imm12_ok;
         end
         OP_S: begin
            w_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            w_err  = !w_imm12_ok;
         end
         default: begin
            w_inst = NOP_WORD;
            w_err  = 1'b1;
         end
      endcase
      if (w_err) begin
         w_inst = NOP_WORD;
      end else begin
         w_inst = w_inst;
      end
   end

   // Single output stage: reload on input accept, drain on output accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid   <= 1'b0;
         r_inst    <= 32'h0000_0000;
         r_err     <= 1'b0;
         r_err_cnt <= {CNT_W{1'b0}};
      end else if (w_in_acc) begin
         r_valid <= 1'b1;
         r_inst  <= w_inst;
         r_err   <= w_err;
         if (w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            r_err_cnt <= r_err_cnt;
         end
      end else if (w_out_acc) begin
         r_valid <= 1'b0;
      end else begin
         r_valid <= r_valid;
      end
   end

   // Address of the presented word; every accepted word, errored or not, consumes one slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr <= BASE_ADDR;
      end else if (w_out_acc) begin
         r_addr <= r_addr + {{(ADDR_W-3){1'b0}}, 3'd4};
      end else begin
         r_addr <= r_addr;
      end
   end

   assign out_valid = r_valid;
   assign inst_o    = r_inst;
   assign addr_o    = r_addr;
   assign err_o     = r_err;
   assign err_cnt_o = r_err_cnt;

endmodule
